// File: rtl/series_eval_p_pkg.sv
// series_pkg: shared types and helpers for the series_eval_p engine.
//   state_t    controller states
//   coef(k)    default coefficient table (1/k! in Q2.14), 0 past the table
//   sat_clamp  clamp a wide signed value into a w-bit two's complement range
package series_pkg;

    typedef enum logic [1:0] {IDLE, TERM, NEXT, DONE} state_t;

    function automatic logic signed [31:0] coef(input int k);
        case (k)
            0:       return 32'sd16384;
            1:       return 32'sd16384;
            2:       return 32'sd8192;
            3:       return 32'sd2731;
            4:       return 32'sd683;
            5:       return 32'sd137;
            6:       return 32'sd23;
            7:       return 32'sd3;
            default: return 32'sd0;
        endcase
    endfunction

    // Wide arithmetic is carried in 64 bits, so w must stay below 32.
    function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v,
                                                     input int w);
        logic signed [63:0] hi, lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        else             return v;
    endfunction

endpackage

// File: rtl/series_eval_p_if.sv
// Request/result bundle between a requester (master) and series_eval_p (slave).
//   start, mode, x, in_y     : request side, sampled by the engine in IDLE
//   out_ans, done, busy, sat : result and status from the engine
interface series_eval_p_if #(
    parameter int W   = 16,
    parameter int Y_W = 8
);
    logic                start;
    logic                mode;
    logic signed [W-1:0] x;
    logic [Y_W-1:0]      in_y;
    logic signed [W-1:0] out_ans;
    logic                done;
    logic                busy;
    logic                sat;

    modport master (output start, mode, x, in_y,
                    input  out_ans, done, busy, sat);
    modport slave  (input  start, mode, x, in_y,
                    output out_ans, done, busy, sat);
endinterface

// File: rtl/series_eval_p_coef_rom.sv
// coef_rom: DEPTH x W combinational coefficient table filled from series_pkg::coef.
//   k : term index (out-of-range indices read as 0)
//   c : signed coefficient c_k
module coef_rom #(
    parameter int W     = 16,
    parameter int DEPTH = 8,
    parameter int K_W   = 4
) (
    input  logic [K_W-1:0]      k,
    output logic signed [W-1:0] c
);
    import series_pkg::*;

    logic [DEPTH-1:0][W-1:0] rom;

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        localparam logic signed [31:0] CV = coef(i);
        assign rom[i] = CV[W-1:0];
    end

    always_comb begin
        c = '0;
        for (int i = 0; i < DEPTH; i++)
            if (k == K_W'(i)) c = rom[i];
    end
endmodule

// File: rtl/series_eval_p.sv
// series_eval_p: iterative evaluator of ans = sum_{k<n} s_k * c_k * x^k in
// signed Q(W-FRAC).FRAC. Each term costs a TERM cycle (accumulate c_k*tmp)
// and a NEXT cycle (tmp *= x); one multiplier is shared between them.
// Runs stop early once |tmp| drops below EPS; ans and tmp saturate and any
// clamp raises sat for the run.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of series_eval_p_if (start/mode/x/in_y in,
//              out_ans/done/busy/sat out)
module series_eval_p #(
    parameter int W     = 16,
    parameter int FRAC  = 14,
    parameter int Y_W   = 8,
    parameter int DEPTH = 8,
    parameter int EPS   = 1
) (
    input  logic           clk,
    input  logic           rst,
    series_eval_p_if.slave bus
);
    import series_pkg::*;

    localparam int K_W = $clog2(DEPTH + 1);
    localparam logic signed [W-1:0] ONE = W'(1 << FRAC);

    state_t              state, state_nx;
    logic signed [W-1:0] tmp, ans, x_r, c_k, op_a, op_b;
    logic [K_W-1:0]      k, n_eff, n_in;
    logic                mode_r, sat_r;
    logic signed [2*W-1:0] prod, prod_sh;
    logic signed [63:0]  p_w, ans_w, acc_w, acc_s, tmp_s;
    logic                acc_clip, tmp_clip, last_term;

    coef_rom #(.W(W), .DEPTH(DEPTH), .K_W(K_W)) u_rom (.k(k), .c(c_k));

    always_comb begin
        n_in = (int'(bus.in_y) > DEPTH) ? K_W'(DEPTH) : K_W'(bus.in_y);
    end

    // Shared multiplier: TERM uses c_k*tmp, NEXT uses x_r*tmp.
    always_comb begin
        op_a    = (state == TERM) ? c_k : x_r;
        op_b    = tmp;
        prod    = {{W{op_a[W-1]}}, op_a} * {{W{op_b[W-1]}}, op_b};
        prod_sh = prod >>> FRAC;
        p_w     = {{(64-2*W){prod_sh[2*W-1]}}, prod_sh};
        ans_w   = {{(64-W){ans[W-1]}}, ans};
        // Odd terms are subtracted only in alternating mode.
        acc_w   = (mode_r && k[0]) ? ans_w - p_w : ans_w + p_w;
        acc_s   = sat_clamp(acc_w, W);
        acc_clip = (acc_s != acc_w);
        tmp_s   = sat_clamp(p_w, W);
        tmp_clip = (tmp_s != p_w);
        last_term = (({1'b0, k} + (K_W+1)'(1)) == {1'b0, n_eff}) ||
                    (((tmp_s < 0) ? -tmp_s : tmp_s) < 64'(EPS));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = (n_in == '0) ? DONE : TERM;
            TERM:    state_nx = NEXT;
            NEXT:    state_nx = last_term ? DONE : TERM;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmp    <= '0;
            ans    <= '0;
            x_r    <= '0;
            k      <= '0;
            n_eff  <= '0;
            mode_r <= 1'b0;
            sat_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    x_r    <= bus.x;
                    mode_r <= bus.mode;
                    n_eff  <= n_in;
                    tmp    <= ONE;
                    ans    <= '0;
                    k      <= '0;
                    sat_r  <= 1'b0;
                end
                TERM: begin
                    ans <= acc_s[W-1:0];
                    if (acc_clip) sat_r <= 1'b1;
                end
                NEXT: begin
                    tmp <= tmp_s[W-1:0];
                    k   <= k + K_W'(1);
                    if (tmp_clip) sat_r <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.out_ans = ans;
    assign bus.done    = (state == DONE);
    assign bus.busy    = (state != IDLE);
    assign bus.sat     = sat_r;
endmodule
